// File: rtl/fib_loop_engine.sv
// Bounded Fibonacci loop engine: INIT, then BOUND TEST/BODY pairs, then POST -> DONE (or ERROR).
// Latency: DONE visible after edge 2*BOUND+3 following reset; no backpressure, selector sampled in BODY only.
module fib_loop_engine #(
    parameter int WIDTH    = 11,
    parameter int BOUND    = 100,
    parameter int SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             selector,
    output logic [2:0]       turn,
    output logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             ovf,
    output logic             err
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_TEST  = 3'd1;
    localparam logic [2:0] S_BODY  = 3'd2;
    localparam logic [2:0] S_POST  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    localparam logic [WIDTH-1:0] BOUND_W = WIDTH'(BOUND);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [WIDTH:0]   sum;
    logic             carry;
    logic [WIDTH-1:0] k_step;

    // Sum is one bit wider than the terms so the carry-out doubles as the overflow event.
    assign sum   = {1'b0, j} + {1'b0, k};
    assign carry = sum[WIDTH];

    always_comb begin
        k_step = sum[WIDTH-1:0];
        if (carry && (SAT_MODE != 0)) begin
            k_step = ALL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  state_nxt = S_TEST;
            S_TEST:  state_nxt = (i < BOUND_W) ? S_BODY : S_POST;
            S_BODY:  state_nxt = S_TEST;
            S_POST:  state_nxt = ((k < j) && !ovf) ? S_ERROR : S_DONE;
            S_DONE:  state_nxt = S_DONE;
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        turn = state;
        done = (state == S_DONE);
        err  = (state == S_ERROR);
    end

    // Data registers change only in INIT and BODY; every other state, including unused encodings, holds them.
    always_ff @(posedge clk) begin
        if (rst) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    i <= '0;
                    j <= '0;
                    k <= ONE;
                end
                S_BODY: begin
                    i <= i + ONE;
                    if (selector) begin
                        j <= k;
                        k <= k_step;
                        if (carry) begin
                            ovf <= 1'b1;
                        end
                    end
                end
                default: begin
                    i <= i;
                    j <= j;
                    k <= k;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_loop_engine.sv
// Self-checking bench for fib_loop_engine: directed loop scenarios plus randomized run against a program-level model.
module tb_fib_loop_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic selector = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // a: W11 B10 wrap, b: W11 B20 wrap, c: W11 B20 saturate, d: W5 B9 wrap (overflow-prone, random)
    logic [2:0]  a_turn, b_turn, c_turn, d_turn;
    logic [10:0] a_i, a_j, a_k, b_i, b_j, b_k, c_i, c_j, c_k;
    logic [4:0]  d_i, d_j, d_k;
    logic        a_done, a_ovf, a_err, b_done, b_ovf, b_err;
    logic        c_done, c_ovf, c_err, d_done, d_ovf, d_err;

    fib_loop_engine #(.WIDTH(11), .BOUND(10), .SAT_MODE(0)) u_a (
        .clk(clk), .rst(rst), .selector(selector), .turn(a_turn), .i(a_i), .j(a_j), .k(a_k),
        .done(a_done), .ovf(a_ovf), .err(a_err));
    fib_loop_engine #(.WIDTH(11), .BOUND(20), .SAT_MODE(0)) u_b (
        .clk(clk), .rst(rst), .selector(selector), .turn(b_turn), .i(b_i), .j(b_j), .k(b_k),
        .done(b_done), .ovf(b_ovf), .err(b_err));
    fib_loop_engine #(.WIDTH(11), .BOUND(20), .SAT_MODE(1)) u_c (
        .clk(clk), .rst(rst), .selector(selector), .turn(c_turn), .i(c_i), .j(c_j), .k(c_k),
        .done(c_done), .ovf(c_ovf), .err(c_err));
    fib_loop_engine #(.WIDTH(5), .BOUND(9), .SAT_MODE(0)) u_d (
        .clk(clk), .rst(rst), .selector(selector), .turn(d_turn), .i(d_i), .j(d_j), .k(d_k),
        .done(d_done), .ovf(d_ovf), .err(d_err));

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Program-level reference for u_d: a program point plus unbounded integer arithmetic reduced mod 2**5.
    localparam int D_BOUND = 9;
    localparam int D_MOD   = 32;
    int m_pc, m_i, m_j, m_k, m_ovf;

    task automatic model_step(input logic r, input logic s);
        int total_sum;
        if (r) begin
            m_pc = 0; m_i = 0; m_j = 0; m_k = 0; m_ovf = 0;
        end else if (m_pc == 0) begin
            m_i = 0; m_j = 0; m_k = 1; m_pc = 1;
        end else if (m_pc == 1) begin
            m_pc = (m_i < D_BOUND) ? 2 : 4;
        end else if (m_pc == 2) begin
            if (s) begin
                total_sum = m_j + m_k;
                if (total_sum >= D_MOD) m_ovf = 1;
                m_j = m_k;
                m_k = total_sum % D_MOD;
            end
            m_i = m_i + 1;
            m_pc = 1;
        end else if (m_pc == 4) begin
            m_pc = (m_k < m_j && m_ovf == 0) ? 6 : 5;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({a_turn, a_i, a_j, a_k, a_ovf, a_done, a_err} !== {3'd0, 11'd0, 11'd0, 11'd0, 3'b000}) begin
            bad++;
            $display("FAIL reset_state: turn=%0d i=%0d j=%0d k=%0d ovf=%b done=%b err=%b want all zero",
                     a_turn, a_i, a_j, a_k, a_ovf, a_done, a_err);
        end
        run_edges(1);
        total++;
        if ({a_turn, a_i, a_j, a_k} !== {3'd1, 11'd0, 11'd0, 11'd1}) begin
            bad++;
            $display("FAIL init_edge: turn=%0d i=%0d j=%0d k=%0d want turn=1 i=0 j=0 k=1", a_turn, a_i, a_j, a_k);
        end
    endtask

    task automatic test_fib_all_steps();
        do_reset();
        selector = 1'b1;
        run_edges(22);
        total++;
        if ({a_turn, a_i, a_done} !== {3'd4, 11'd10, 1'b0}) begin
            bad++;
            $display("FAIL post_edge22: turn=%0d i=%0d done=%b want turn=4 i=10 done=0", a_turn, a_i, a_done);
        end
        run_edges(1);
        total++;
        if ({a_turn, a_i, a_j, a_k, a_done, a_ovf, a_err} !== {3'd5, 11'd10, 11'd55, 11'd89, 3'b100}) begin
            bad++;
            $display("FAIL fib_b10: turn=%0d i=%0d j=%0d k=%0d done=%b ovf=%b err=%b want 5/10/55/89/1/0/0",
                     a_turn, a_i, a_j, a_k, a_done, a_ovf, a_err);
        end
        run_edges(5);
        total++;
        if ({a_turn, a_i, a_j, a_k, a_done} !== {3'd5, 11'd10, 11'd55, 11'd89, 1'b1}) begin
            bad++;
            $display("FAIL done_hold: turn=%0d i=%0d j=%0d k=%0d done=%b want 5/10/55/89/1",
                     a_turn, a_i, a_j, a_k, a_done);
        end
    endtask

    task automatic test_noop();
        do_reset();
        selector = 1'b0;
        run_edges(23);
        total++;
        if ({a_turn, a_i, a_j, a_k, a_done, a_ovf} !== {3'd5, 11'd10, 11'd0, 11'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL noop_b10: turn=%0d i=%0d j=%0d k=%0d done=%b ovf=%b want 5/10/0/1/1/0",
                     a_turn, a_i, a_j, a_k, a_done, a_ovf);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        selector = 1'b1;
        run_edges(34);
        total++;
        if ({b_ovf, b_j, b_k, b_i} !== {1'b0, 11'd987, 11'd1597, 11'd16}) begin
            bad++;
            $display("FAIL pre_ovf: ovf=%b j=%0d k=%0d i=%0d want 0/987/1597/16", b_ovf, b_j, b_k, b_i);
        end
        run_edges(1);
        total++;
        if ({b_ovf, b_j, b_k, b_i} !== {1'b1, 11'd1597, 11'd536, 11'd17}) begin
            bad++;
            $display("FAIL wrap_iter17: ovf=%b j=%0d k=%0d i=%0d want 1/1597/536/17", b_ovf, b_j, b_k, b_i);
        end
        total++;
        if ({c_ovf, c_j, c_k} !== {1'b1, 11'd1597, 11'd2047}) begin
            bad++;
            $display("FAIL sat_iter17: ovf=%b j=%0d k=%0d want 1/1597/2047", c_ovf, c_j, c_k);
        end
        run_edges(8);
        total++;
        if ({b_turn, b_err, b_done, b_ovf, b_i} !== {3'd5, 1'b0, 1'b1, 1'b1, 11'd20}) begin
            bad++;
            $display("FAIL wrap_end: turn=%0d err=%b done=%b ovf=%b i=%0d want 5/0/1/1/20",
                     b_turn, b_err, b_done, b_ovf, b_i);
        end
        total++;
        if ({c_turn, c_j, c_k, c_ovf, c_done, c_err} !== {3'd5, 11'd2047, 11'd2047, 3'b110}) begin
            bad++;
            $display("FAIL sat_end: turn=%0d j=%0d k=%0d ovf=%b done=%b err=%b want 5/2047/2047/1/1/0",
                     c_turn, c_j, c_k, c_ovf, c_done, c_err);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        selector = 1'b1;
        run_edges(10);
        total++;
        if ({a_turn, a_i} !== {3'd2, 11'd4}) begin
            bad++;
            $display("FAIL iter5_body: turn=%0d i=%0d want turn=2 i=4", a_turn, a_i);
        end
        rst = 1'b1;
        run_edges(1);
        rst = 1'b0;
        total++;
        if ({a_turn, a_i, a_j, a_k, a_ovf, a_done} !== {3'd0, 11'd0, 11'd0, 11'd0, 2'b00}) begin
            bad++;
            $display("FAIL mid_reset: turn=%0d i=%0d j=%0d k=%0d ovf=%b done=%b want all zero",
                     a_turn, a_i, a_j, a_k, a_ovf, a_done);
        end
        run_edges(23);
        total++;
        if ({a_turn, a_i, a_j, a_k, a_done} !== {3'd5, 11'd10, 11'd55, 11'd89, 1'b1}) begin
            bad++;
            $display("FAIL rerun: turn=%0d i=%0d j=%0d k=%0d done=%b want 5/10/55/89/1",
                     a_turn, a_i, a_j, a_k, a_done);
        end
    endtask

    task automatic test_random();
        logic [20:0] exp_d;
        do_reset();
        model_step(1'b1, 1'b0);
        for (int c = 0; c < 1000; c++) begin
            rst = ((c % 97) == 96) || ($urandom_range(0, 199) == 0);
            selector = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            model_step(rst, selector);
            @(negedge clk);
            exp_d = {m_pc[2:0], m_i[4:0], m_j[4:0], m_k[4:0], m_ovf[0], (m_pc == 5), (m_pc == 6)};
            total++;
            if ({d_turn, d_i, d_j, d_k, d_ovf, d_done, d_err} !== exp_d) begin
                bad++;
                $display("FAIL rand_model c=%0d: turn=%0d i=%0d j=%0d k=%0d ovf=%b done=%b err=%b want %0d/%0d/%0d/%0d/%0d",
                         c, d_turn, d_i, d_j, d_k, d_ovf, d_done, d_err, m_pc, m_i, m_j, m_k, m_ovf);
            end
            total++;
            if (a_err !== 1'b0 || a_i > 11'd10 || (a_ovf === 1'b0 && a_k < a_j)) begin
                bad++;
                $display("FAIL rand_invariant c=%0d: err=%b i=%0d j=%0d k=%0d ovf=%b want err=0 i<=10 k>=j",
                         c, a_err, a_i, a_j, a_k, a_ovf);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_fib_all_steps();
        test_noop();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
